// File: rtl/ysyx_25040109_mux_key_with_default.sv
// Key-lookup multiplexer with default.
// Compares `key` against every (key, data) entry of the packed table `lut`. It drives the OR of
// the data of all matching entries, or `default_out` when nothing matches. It also reports
// hit / lowest hit index / multi-hit. A registered copy of out/hit is kept for pipelined users.
//
// Ports:
//   clk         clock for out_r/hit_r only
//   rst         synchronous active-high reset, clears out_r/hit_r only
//   key         lookup key
//   default_out value driven on a miss
//   lut         NR_KEY entries; entry i at [(i+1)*W-1 : i*W], key in the upper KEY_LEN bits
//   out         combinational lookup result
//   hit         combinational, any entry matched
//   hit_idx     combinational, lowest matching index (0 on miss)
//   multi_hit   combinational, two or more entries matched
//   out_r/hit_r out/hit registered on rising clk
module ysyx_25040109_mux_key_with_default #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [KEY_LEN-1:0]                             key,
  input  logic [DATA_LEN-1:0]                            default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]           lut,
  output logic [DATA_LEN-1:0]                            out,
  output logic                                           hit,
  output logic [((NR_KEY > 1) ? $clog2(NR_KEY) : 1)-1:0] hit_idx,
  output logic                                           multi_hit,
  output logic [DATA_LEN-1:0]                            out_r,
  output logic                                           hit_r
);

  localparam int W     = KEY_LEN + DATA_LEN;
  localparam int IDX_W = (NR_KEY > 1) ? $clog2(NR_KEY) : 1;

  logic [DATA_LEN-1:0] w_or_data;
  logic [IDX_W-1:0]    w_idx;
  logic                w_hit;
  logic                w_multi;

  logic [DATA_LEN-1:0] r_out;
  logic                r_hit;

  // Scan from the top down so the last assignment to w_idx is the lowest matching index.
  // w_multi is set when a match is found after one has already been seen.
  always_comb begin
    w_or_data = '0;
    w_idx     = '0;
    w_hit     = 1'b0;
    w_multi   = 1'b0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (lut[i*W + DATA_LEN +: KEY_LEN] == key) begin
        if (w_hit) begin
          w_multi = 1'b1;
        end
        w_hit     = 1'b1;
        w_idx     = IDX_W'(unsigned'(i));
        w_or_data = w_or_data | lut[i*W +: DATA_LEN];
      end
    end
  end

  assign out       = w_hit ? w_or_data : default_out;
  assign hit       = w_hit;
  assign hit_idx   = w_idx;
  assign multi_hit = w_multi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_hit <= 1'b0;
    end else begin
      r_out <= out;
      r_hit <= hit;
    end
  end

  assign out_r = r_out;
  assign hit_r = r_hit;

endmodule

// File: tb/tb_ysyx_25040109_mux_key_with_default.sv
module tb_ysyx_25040109_mux_key_with_default;

  localparam int NK = 8;
  localparam int KL = 7;
  localparam int DL = 32;
  localparam int W  = KL + DL;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [KL-1:0]   key = '0;
  logic [DL-1:0]   default_out = '0;
  logic [NK*W-1:0] lut = '0;
  logic [DL-1:0]   out;
  logic            hit;
  logic [2:0]      hit_idx;
  logic            multi_hit;
  logic [DL-1:0]   out_r;
  logic            hit_r;

  int checks   = 0;
  int failures = 0;

  // Table model: index i holds tkey[i] -> tdat[i].
  logic [KL-1:0] tkey [NK];
  logic [DL-1:0] tdat [NK];

  ysyx_25040109_mux_key_with_default #(
    .NR_KEY  (NK),
    .KEY_LEN (KL),
    .DATA_LEN(DL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .default_out(default_out),
    .lut        (lut),
    .out        (out),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .multi_hit  (multi_hit),
    .out_r      (out_r),
    .hit_r      (hit_r)
  );

  always #5 clk = ~clk;

  function automatic void load_default_table();
    tkey[7] = 7'h17; tdat[7] = 32'h12345000;
    tkey[6] = 7'h37; tdat[6] = 32'hABCDE000;
    tkey[5] = 7'h13; tdat[5] = 32'hFFFFF800;
    tkey[4] = 7'h03; tdat[4] = 32'h00000004;
    tkey[3] = 7'h67; tdat[3] = 32'hFFFFFFFC;
    tkey[2] = 7'h23; tdat[2] = 32'h00000010;
    tkey[1] = 7'h6F; tdat[1] = 32'h00000800;
    tkey[0] = 7'h63; tdat[0] = 32'hFFFFF000;
  endfunction

  function automatic logic [NK*W-1:0] pack_table();
    logic [NK*W-1:0] v = '0;
    for (int i = 0; i < NK; i++) v[i*W +: W] = {tkey[i], tdat[i]};
    return v;
  endfunction

  // Reference: OR of matching data, lowest index, count of matches.
  function automatic void model(input logic [KL-1:0] k, input logic [DL-1:0] dflt,
                                output logic [DL-1:0] eo, output logic eh,
                                output logic [2:0] ei, output logic em);
    int n = 0;
    eo = '0;
    ei = '0;
    for (int i = 0; i < NK; i++) begin
      if (tkey[i] == k) begin
        if (n == 0) ei = 3'(i);
        n++;
        eo |= tdat[i];
      end
    end
    eh = (n > 0);
    em = (n > 1);
    if (!eh) eo = dflt;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    load_default_table();
    lut = pack_table();
    key = 7'h37;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_r !== 32'h0 || hit_r !== 1'b0) begin
      failures++;
      $display("FAIL reset: out_r=%h hit_r=%b required 0/0", out_r, hit_r);
    end
  endtask

  task automatic test_lookup();
    @(negedge clk);
    rst = 1'b0;
    default_out = 32'h0;
    // Literal concatenation, first pair lands at index NR_KEY-1.
    lut = {7'h17, 32'h12345000, 7'h37, 32'hABCDE000, 7'h13, 32'hFFFFF800, 7'h03, 32'h00000004,
           7'h67, 32'hFFFFFFFC, 7'h23, 32'h00000010, 7'h6F, 32'h00000800, 7'h63, 32'hFFFFF000};
    key = 7'h37;
    #1;
    checks++;
    if (out !== 32'hABCDE000 || hit !== 1'b1 || hit_idx !== 3'd6 || multi_hit !== 1'b0) begin
      failures++;
      $display("FAIL lookup_37: out=%h hit=%b idx=%0d multi=%b required abcde000/1/6/0",
               out, hit, hit_idx, multi_hit);
    end
    key = 7'h63;
    #1;
    checks++;
    if (out !== 32'hFFFFF000 || hit !== 1'b1 || hit_idx !== 3'd0) begin
      failures++;
      $display("FAIL lookup_63: out=%h hit=%b idx=%0d required fffff000/1/0", out, hit, hit_idx);
    end
    key = 7'h33;
    #1;
    checks++;
    if (out !== 32'h0 || hit !== 1'b0 || hit_idx !== 3'd0 || multi_hit !== 1'b0) begin
      failures++;
      $display("FAIL miss_zero: out=%h hit=%b idx=%0d multi=%b required 0/0/0/0",
               out, hit, hit_idx, multi_hit);
    end
    default_out = 32'hDEADBEEF;
    #1;
    checks++;
    if (out !== 32'hDEADBEEF || hit !== 1'b0) begin
      failures++;
      $display("FAIL miss_default: out=%h hit=%b required deadbeef/0", out, hit);
    end
    default_out = 32'h0;
  endtask

  task automatic test_sweep();
    int nhits = 0;
    int bad   = 0;
    logic [DL-1:0] eo;
    logic eh, em;
    logic [2:0] ei;
    load_default_table();
    lut = pack_table();
    for (int k = 0; k < 128; k++) begin
      key = 7'(k);
      #1;
      model(7'(k), default_out, eo, eh, ei, em);
      if (hit === 1'b1) nhits++;
      checks++;
      if (out !== eo || hit !== eh || hit_idx !== ei || multi_hit !== em) begin
        failures++;
        bad++;
        if (bad < 5)
          $display("FAIL sweep key=%h: out=%h hit=%b idx=%0d multi=%b required %h/%b/%0d/%b",
                   7'(k), out, hit, hit_idx, multi_hit, eo, eh, ei, em);
      end
    end
    checks++;
    if (nhits != 8) begin
      failures++;
      $display("FAIL sweep_hit_count: got %0d required 8", nhits);
    end
  endtask

  task automatic test_duplicate();
    load_default_table();
    tkey[0] = 7'h17;
    lut = pack_table();
    key = 7'h17;
    #1;
    checks++;
    if (out !== 32'hFFFFF000 || hit !== 1'b1 || hit_idx !== 3'd0 || multi_hit !== 1'b1) begin
      failures++;
      $display("FAIL duplicate: out=%h hit=%b idx=%0d multi=%b required fffff000/1/0/1",
               out, hit, hit_idx, multi_hit);
    end
  endtask

  task automatic test_random();
    logic [DL-1:0] eo;
    logic eh, em;
    logic [2:0] ei;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (t % 8 == 0) begin
        // Narrow key range so duplicates and misses both occur.
        for (int i = 0; i < NK; i++) begin
          tkey[i] = 7'($urandom_range(0, 15));
          tdat[i] = $urandom;
        end
        lut = pack_table();
        default_out = $urandom;
      end
      key = 7'($urandom_range(0, 15));
      #1;
      model(key, default_out, eo, eh, ei, em);
      checks++;
      if (out !== eo || hit !== eh || hit_idx !== ei || multi_hit !== em) begin
        failures++;
        $display("FAIL random key=%h: out=%h hit=%b idx=%0d multi=%b required %h/%b/%0d/%b",
                 key, out, hit, hit_idx, multi_hit, eo, eh, ei, em);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_r !== eo || hit_r !== eh) begin
        failures++;
        $display("FAIL random_reg: out_r=%h hit_r=%b required %h/%b", out_r, hit_r, eo, eh);
      end
    end
  endtask

  task automatic test_registered();
    load_default_table();
    lut = pack_table();
    default_out = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    key = 7'h37;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_r !== 32'h0 || hit_r !== 1'b0) begin
      failures++;
      $display("FAIL reg_reset: out_r=%h hit_r=%b required 0/0", out_r, hit_r);
    end
    @(negedge clk);
    rst = 1'b0;
    key = 7'h13;
    @(posedge clk);
    #1;
    checks++;
    if (out_r !== 32'hFFFFF800 || hit_r !== 1'b1) begin
      failures++;
      $display("FAIL reg_capture: out_r=%h hit_r=%b required fffff800/1", out_r, hit_r);
    end
    @(negedge clk);
    key = 7'h33;
    @(posedge clk);
    #1;
    checks++;
    if (out_r !== 32'h0 || hit_r !== 1'b0) begin
      failures++;
      $display("FAIL reg_miss: out_r=%h hit_r=%b required 0/0", out_r, hit_r);
    end
  endtask

  task automatic test_back_to_back_reset();
    @(negedge clk);
    key = 7'h6F;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 32'h00000800 || out_r !== 32'h00000800) begin
      failures++;
      $display("FAIL midreset_pre: out=%h out_r=%h required 00000800/00000800", out, out_r);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h00000800 || out_r !== 32'h0 || hit_r !== 1'b0) begin
      failures++;
      $display("FAIL midreset_clear: out=%h out_r=%h hit_r=%b required 00000800/0/0",
               out, out_r, hit_r);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_r !== 32'h00000800 || hit_r !== 1'b1) begin
      failures++;
      $display("FAIL midreset_release: out_r=%h hit_r=%b required 00000800/1", out_r, hit_r);
    end
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_sweep();
    test_duplicate();
    test_random();
    test_registered();
    test_back_to_back_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
